// File: rtl/fmps_stream_pkg.sv
// Shared definitions for the FMPS readout streamer: FSM state encoding,
// CSR bit positions and the trailer index helper.
package fmps_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WAIT,
        ST_HOLD,
        ST_TRAILER
    } state_e;

    localparam int ACTIVE_BIT = 31;
    localparam int VALID_BIT  = 30;

    localparam int MAX_INDEX_WIDTH = 16;

    // All-ones index of the given width, used to tag trailer beats.
    function automatic logic [MAX_INDEX_WIDTH-1:0] trailer_index(input int w);
        logic [MAX_INDEX_WIDTH-1:0] ones;
        ones = '1;
        return ones >> (MAX_INDEX_WIDTH - w);
    endfunction

endpackage

// File: rtl/fmps_trigger_detect.sv
// Readout trigger detection: CSR edge detect, one-deep pending latch and
// saturating missed-trigger counter.
// Ports: clk_i, rst_i (sync, active high), readout_active_i,
//   readout_valid_i, busy_i (scan in progress) -> start_o (start a scan
//   this cycle), missed_o (dropped trigger count).
module fmps_trigger_detect #(
    parameter int MISSED_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    readout_active_i,
    input  logic                    readout_valid_i,
    input  logic                    busy_i,
    output logic                    start_o,
    output logic [MISSED_WIDTH-1:0] missed_o
);

    logic                    active_q;
    logic                    valid_q;
    logic                    pending_q;
    logic                    pending_d;
    logic [MISSED_WIDTH-1:0] missed_q;
    logic [MISSED_WIDTH-1:0] missed_d;
    logic                    trig;

    // Both edge sources in one cycle collapse into a single trigger.
    assign trig = (readout_valid_i & ~valid_q)
                | (~readout_active_i & active_q);

    assign start_o  = ~busy_i & (trig | pending_q);
    assign missed_o = missed_q;

    always_comb begin
        pending_d = pending_q;
        missed_d  = missed_q;
        if (start_o) begin
            pending_d = 1'b0;
        end else if (busy_i && trig) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (missed_q != '1) begin
                missed_d = missed_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q  <= 1'b0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            missed_q  <= '0;
        end else begin
            active_q  <= readout_active_i;
            valid_q   <= readout_valid_i;
            pending_q <= pending_d;
            missed_q  <= missed_d;
        end
    end

endmodule

// File: rtl/fmps_readout_streamer.sv
// FMPS readout streamer: snapshots the presence bitmap on a trigger, walks
// the readout RAM and streams present entries as (index, data) beats with
// valid/ready handshake and a last flag.
// Ports: sysClk, sysReset (sync, active high), fmpsCSR, fmpsBitmapAll,
//   fmpsReadoutAddress/fmpsReadout (RAM), fmpsIndex/fmpsData/fmpsValid/
//   fmpsReady/fmpsLast (beat stream), fmpsBusy, fmpsMissedCount.
// Build option FMPS_STREAM_TRAILER_EN: append a trailer beat carrying the
//   beat count (index all-ones, last=1) after every scan.
module fmps_readout_streamer
    import fmps_stream_pkg::*;
#(
    parameter int INDEX_WIDTH  = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int MISSED_WIDTH = 16
) (
    input  logic                     sysClk,
    input  logic                     sysReset,
    input  logic [31:0]              fmpsCSR,
    input  logic [2**INDEX_WIDTH-1:0] fmpsBitmapAll,
    output logic [INDEX_WIDTH-1:0]   fmpsReadoutAddress,
    input  logic [DATA_WIDTH-1:0]    fmpsReadout,
    output logic [INDEX_WIDTH-1:0]   fmpsIndex,
    output logic [DATA_WIDTH-1:0]    fmpsData,
    output logic                     fmpsValid,
    input  logic                     fmpsReady,
    output logic                     fmpsLast,
    output logic                     fmpsBusy,
    output logic [MISSED_WIDTH-1:0]  fmpsMissedCount
);

    localparam int N = 2**INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_e                 state_q;
    logic [N-1:0]           snap_q;
    logic [INDEX_WIDTH-1:0] addr_q;
    logic [2:0]             cnt_q;
    logic [2:0]             cnt_d;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   valid_q;
    logic                   last_q;
    logic                   fin_q;

    logic                   start;
    logic                   busy;
    logic                   hit;
    logic [N-1:0]           above;
    logic                   final_w;
    logic                   unused_csr;

`ifdef FMPS_STREAM_TRAILER_EN
    localparam logic [INDEX_WIDTH-1:0] TRAILER_IDX =
        INDEX_WIDTH'(trailer_index(INDEX_WIDTH));
    logic [INDEX_WIDTH:0]   beats_q;
`endif

    assign busy    = (state_q != ST_IDLE);
    assign hit     = snap_q[addr_q];
    // Snapshot bits strictly above the current address.
    assign above   = (snap_q >> addr_q) >> 1;
    assign final_w = (above == '0);
    assign cnt_d   = cnt_q - 3'd1;

    assign unused_csr = ^{fmpsCSR[29:0]};

    fmps_trigger_detect #(
        .MISSED_WIDTH (MISSED_WIDTH)
    ) u_trig (
        .clk_i            (sysClk),
        .rst_i            (sysReset),
        .readout_active_i (fmpsCSR[ACTIVE_BIT]),
        .readout_valid_i  (fmpsCSR[VALID_BIT]),
        .busy_i           (busy),
        .start_o          (start),
        .missed_o         (fmpsMissedCount)
    );

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            index_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            fin_q   <= 1'b0;
`ifdef FMPS_STREAM_TRAILER_EN
            beats_q <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        snap_q  <= fmpsBitmapAll;
                        addr_q  <= '0;
                        state_q <= ST_SCAN;
`ifdef FMPS_STREAM_TRAILER_EN
                        beats_q <= '0;
`endif
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        cnt_q   <= LAT;
                        state_q <= ST_WAIT;
                    end else if (addr_q == ADDR_MAX) begin
                        addr_q  <= '0;
`ifdef FMPS_STREAM_TRAILER_EN
                        index_q <= TRAILER_IDX;
                        data_q  <= DATA_WIDTH'(beats_q);
                        valid_q <= 1'b1;
                        last_q  <= 1'b1;
                        state_q <= ST_TRAILER;
`else
                        state_q <= ST_IDLE;
`endif
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == 3'd0) begin
                        data_q  <= fmpsReadout;
                        index_q <= addr_q;
                        valid_q <= 1'b1;
                        fin_q   <= final_w;
`ifdef FMPS_STREAM_TRAILER_EN
                        last_q  <= 1'b0;
`else
                        last_q  <= final_w;
`endif
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (valid_q && fmpsReady) begin
                        valid_q <= 1'b0;
`ifdef FMPS_STREAM_TRAILER_EN
                        beats_q <= beats_q + 1'b1;
`endif
                        if (fin_q || addr_q == ADDR_MAX) begin
                            addr_q  <= '0;
`ifdef FMPS_STREAM_TRAILER_EN
                            index_q <= TRAILER_IDX;
                            data_q  <= DATA_WIDTH'(beats_q + 1'b1);
                            valid_q <= 1'b1;
                            last_q  <= 1'b1;
                            state_q <= ST_TRAILER;
`else
                            state_q <= ST_IDLE;
`endif
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (valid_q && fmpsReady) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fmpsReadoutAddress = addr_q;
    assign fmpsIndex          = index_q;
    assign fmpsData           = data_q;
    assign fmpsValid          = valid_q;
    assign fmpsLast           = last_q;
    assign fmpsBusy           = busy;

endmodule

// File: doc/fmps_readout_streamer.md
Name: fmps_readout_streamer

Overview:
- Parametrised next generation of the FMPS readout streamer in the sysClk domain.
- Snapshots the FMPS presence bitmap on a readout trigger and walks the readout RAM address.
- Streams only present entries as (index, data) beats with valid/ready backpressure and a last-beat flag.
- Adds configurable RAM read latency, a one-deep pending-trigger latch and a missed-trigger counter; feeds the cell packet/DMA path.

Parameters:
- INDEX_WIDTH, 5: FMPS index width; 2**INDEX_WIDTH entries.
- DATA_WIDTH, 32: readout word width.
- READ_LATENCY, 1: cycles from address change to valid fmpsReadout; legal range 1..4.
- MISSED_WIDTH, 16: width of the missed-trigger counter.

Ports:
- sysClk  in  1  system clock; single clock domain.
- sysReset  in  1  synchronous, active-high reset.
- fmpsCSR  in  32  bit31 readoutActive, bit30 readoutValid; other bits ignored.
- fmpsBitmapAll  in  2**INDEX_WIDTH  per-index packet-present bitmap.
- fmpsReadoutAddress  out  INDEX_WIDTH  readout RAM address.
- fmpsReadout  in  DATA_WIDTH  readout RAM data.
- fmpsIndex  out  INDEX_WIDTH  index of the current beat.
- fmpsData  out  DATA_WIDTH  data of the current beat.
- fmpsValid  out  1  beat valid.
- fmpsReady  in  1  downstream accepts the beat.
- fmpsLast  out  1  current beat is the final present entry of the scan.
- fmpsBusy  out  1  high while a scan is in progress.
- fmpsMissedCount  out  MISSED_WIDTH  saturating count of dropped triggers.

Behaviour:
- Reset: all outputs 0; state IDLE; pending latch clear; CSR delay registers 0. Reset mid-scan aborts the scan and drops fmpsValid in the next cycle with no handshake.
- Trigger sources: readoutValid rising edge, or readoutActive falling edge. Both are compared against the previous cycle's registered CSR bits. Two sources in the same cycle count as one trigger.
- IDLE: on a trigger or a pending trigger, clear pending, latch fmpsBitmapAll into snapshot, set address 0, go to SCAN.
- SCAN: if snapshot[address]=1, go to WAIT and load the latency counter with READ_LATENCY. Otherwise, if address is at maximum, go to IDLE; else increment address. Absent entries cost one cycle each.
- WAIT: decrement the counter. At 0, register fmpsReadout into fmpsData and address into fmpsIndex, set fmpsValid=1, set fmpsLast = no snapshot bit above the current address, then go to HOLD.
- HOLD: hold all beat outputs stable until fmpsValid&&fmpsReady.
  - On the handshake, clear fmpsValid.
  - If last or address at maximum, go to IDLE with address 0.
  - Otherwise increment address and go to SCAN.
- Latency: with snapshot bit 0 set, fmpsValid first rises READ_LATENCY+2 cycles after the trigger-detection cycle.
- Back-to-back beats: fmpsValid is low for at least READ_LATENCY+1 cycles between beats.
- fmpsBusy is high in every state except IDLE.
- Trigger while busy:
  - Pending clear: set pending.
  - Pending already set: increment fmpsMissedCount, saturating at all-ones.
- Empty snapshot: the scan takes 2**INDEX_WIDTH cycles and emits no beats.
- Bitmap changes during a scan are ignored; the snapshot governs the whole scan.

Optional Feature:
- Macro: FMPS_STREAM_TRAILER_EN.
- Defined:
  - After the final data beat, or after an empty scan, emit one trailer beat.
  - Trailer: fmpsIndex = all-ones, fmpsData = zero-extended count of beats emitted this scan, fmpsLast=1.
  - Data beats then carry fmpsLast=0.
  - The trailer obeys the same handshake in its own TRAILER state, entered where IDLE would be.
- Undefined: no trailer; fmpsLast marks the final data beat; an empty scan emits nothing.

Decomposition:
- Package fmps_stream_pkg:
  - state encoding: IDLE, SCAN, WAIT, HOLD, TRAILER;
  - CSR bit positions: ACTIVE_BIT=31, VALID_BIT=30;
  - trailer index constant.
- Sub-module fmps_trigger_detect: CSR edge detection, pending latch and saturating missed counter. It outputs a start pulse and accepts a busy input.

Test Plan:
- Bitmap 0x00000005, READ_LATENCY=1, fmpsReady tied 1, readoutValid 0->1: two beats, (index 0, data RAM[0], last=0) then (index 2, data RAM[2], last=1); first valid 3 cycles after detection.
- Same setup, READ_LATENCY=3, fmpsReady low for 10 cycles on the first beat: fmpsIndex, fmpsData and fmpsLast stay constant while held; the second beat follows; no beat is lost or duplicated.
- readoutActive 1->0 while busy, then readoutValid 0->1 in the same scan: one trigger pending, fmpsMissedCount=1; the second scan starts in the cycle after IDLE is reached.
- Bitmap 0x80000000 changed to 0x1 mid-scan: exactly one beat, index 31, last=1.
- Empty bitmap: fmpsBusy high for 32 cycles, no beats. With FMPS_STREAM_TRAILER_EN: one trailer with index 31, data 0, last=1.
- sysReset asserted during HOLD: next cycle fmpsValid=0, fmpsBusy=0, address=0, fmpsMissedCount=0; a subsequent trigger performs a full normal scan.
